hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/lib_pkg.sv | 13 +
 rtl/fwd_unit.sv | 20 ++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lib_pkg.sv
// lib_pkg: shared hazard-controller state encoding and forwarding select codes
//   hz_state_t : HZ_RUN=0, HZ_DRAIN=1, HZ_HALT=2
//   FWD_*      : EX operand source select (register file, MEM stage, WB stage)
package lib_pkg;
  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_DRAIN = 2'd1,
    HZ_HALT  = 2'd2
  } hz_state_t;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: forwarding select for one EX source operand
//   rs            : source register of the EX instruction
//   rd_mem/wr_en_mem, rd_wb/wr_en_wb : pending writers in MEM and WB
//   sel           : FWD_MEM, FWD_WB or FWD_RF (MEM is the younger value, so it wins)
module fwd_unit
  import lib_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_mem,
  input  logic       wr_en_mem,
  input  logic [4:0] rd_wb,
  input  logic       wr_en_wb,
  output logic [1:0] sel
);
  logic hit_mem;
  logic hit_wb;
  assign hit_mem = wr_en_mem && rd_mem != 5'd0 && rd_mem == rs;
  assign hit_wb  = wr_en_wb && rd_wb != 5'd0 && rd_wb == rs;
  assign sel     = hit_mem ? FWD_MEM : hit_wb ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, redirect flush and ecall drain/halt control
//   Inputs : clk, reset (async, active high), ID/EX register ids, EX/MEM/WB writers,
//            load_ex, ecall_id, redirect_ex
//   Outputs: sel_rdata1_f/sel_rdata2_f, stall_if, stall_id, flush_id, flush_ex, halted
//   Option : HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt performance counters
module hazard_ctrl
  import lib_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rs1_id,
  input  logic [4:0]           rs2_id,
  input  logic [4:0]           rs1_ex,
  input  logic [4:0]           rs2_ex,
  input  logic [4:0]           rd_ex,
  input  logic [4:0]           rd_mem,
  input  logic [4:0]           rd_wb,
  input  logic                 wr_en_ex,
  input  logic                 wr_en_mem,
  input  logic                 wr_en_wb,
  input  logic                 load_ex,
  input  logic                 ecall_id,
  input  logic                 redirect_ex,
  output logic [1:0]           sel_rdata1_f,
  output logic [1:0]           sel_rdata2_f,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 flush_ex,
`ifdef HAZARD_PERF_EN
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
`endif
  output logic                 halted
);
  hz_state_t  state;
  hz_state_t  state_n;
  logic [1:0] drain_cnt;
  logic [1:0] drain_cnt_n;
  logic       load_use;
  fwd_unit u_fwd1 (
    .rs        (rs1_ex),
    .rd_mem    (rd_mem),
    .wr_en_mem (wr_en_mem),
    .rd_wb     (rd_wb),
    .wr_en_wb  (wr_en_wb),
    .sel       (sel_rdata1_f)
  );
  fwd_unit u_fwd2 (
    .rs        (rs2_ex),
    .rd_mem    (rd_mem),
    .wr_en_mem (wr_en_mem),
    .rd_wb     (rd_wb),
    .wr_en_wb  (wr_en_wb),
    .sel       (sel_rdata2_f)
  );
  assign load_use = load_ex && wr_en_ex && rd_ex != 5'd0 && (rd_ex == rs1_id || rd_ex == rs2_id);
  assign halted   = state == HZ_HALT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HZ_RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
    end
  end
  // A taken redirect squashes the load's consumer in ID, so it overrides the stall;
  // an ecall is only accepted on a clean cycle so it never retires alongside a bubble.
  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    case (state)
      HZ_RUN: begin
        stall_if = load_use && !redirect_ex;
        stall_id = load_use && !redirect_ex;
        flush_id = redirect_ex;
        flush_ex = redirect_ex || load_use;
        state_n  = (ecall_id && !redirect_ex && !load_use) ? HZ_DRAIN : HZ_RUN;
        drain_cnt_n = 2'd0;
      end
      HZ_DRAIN: begin
        stall_if    = 1'b1;
        flush_id    = 1'b1;
        state_n     = drain_cnt == 2'd2 ? HZ_HALT : HZ_DRAIN;
        drain_cnt_n = drain_cnt == 2'd2 ? 2'd0 : drain_cnt + 2'd1;
      end
      HZ_HALT: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      default: state_n = HZ_RUN;
    endcase
  end
`ifdef HAZARD_PERF_EN
  logic stall_ev;
  logic flush_ev;
  assign stall_ev = state == HZ_RUN && load_use && !redirect_ex;
  assign flush_ev = state == HZ_RUN && redirect_ex;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_ev && ~&flush_cnt) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus drain/halt/reset sequences for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic wr_en_ex, wr_en_mem, wr_en_wb, load_ex, ecall_id, redirect_ex;
  logic [1:0] sel_rdata1_f, sel_rdata2_f;
  logic stall_if, stall_id, flush_id, flush_ex, halted;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif
  int n_vec = 0;
  int n_bad = 0;
  hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_ex       (rs1_ex),
    .rs2_ex       (rs2_ex),
    .rd_ex        (rd_ex),
    .rd_mem       (rd_mem),
    .rd_wb        (rd_wb),
    .wr_en_ex     (wr_en_ex),
    .wr_en_mem    (wr_en_mem),
    .wr_en_wb     (wr_en_wb),
    .load_ex      (load_ex),
    .ecall_id     (ecall_id),
    .redirect_ex  (redirect_ex),
    .sel_rdata1_f (sel_rdata1_f),
    .sel_rdata2_f (sel_rdata2_f),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
`ifdef HAZARD_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .halted       (halted)
  );
  always #5 clk = ~clk;
  // Expected output word: {sel1[1:0], sel2[1:0], stall_if, stall_id, flush_id, flush_ex, halted}
  typedef struct {
    logic [4:0] r1i, r2i, r1e, r2e, rde, rdm, rdw;
    logic [5:0] flg;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[15];
  function automatic vec_t mk(input logic [4:0] r1i, r2i, r1e, r2e, rde, rdm, rdw,
                              input logic [5:0] flg, input logic [8:0] exp);
    vec_t v;
    v.r1i = r1i; v.r2i = r2i; v.r1e = r1e; v.r2e = r2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.flg = flg; v.exp = exp;
    return v;
  endfunction
  function automatic logic [8:0] outs();
    return {sel_rdata1_f, sel_rdata2_f, stall_if, stall_id, flush_id, flush_ex, halted};
  endfunction
  task automatic drive(input vec_t v);
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = {v.r1i, v.r2i, v.r1e, v.r2e, v.rde, v.rdm, v.rdw};
    {wr_en_ex, wr_en_mem, wr_en_wb, load_ex, ecall_id, redirect_ex} = v.flg;
  endtask
  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 6'b0, 9'h0));
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask
  initial begin
    // flags: {wr_en_ex, wr_en_mem, wr_en_wb, load_ex, ecall_id, redirect_ex}
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b000000, 9'h000);
    tbl[1]  = mk(0, 0, 5, 0, 0, 5, 5, 6'b011000, 9'h080);
    tbl[2]  = mk(0, 0, 5, 0, 0, 5, 5, 6'b001000, 9'h100);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 6'b010000, 9'h000);
    tbl[4]  = mk(0, 0, 0, 9, 0, 0, 9, 6'b001000, 9'h040);
    tbl[5]  = mk(0, 0, 3, 3, 0, 3, 0, 6'b010000, 9'h0A0);
    tbl[6]  = mk(0, 0, 4, 0, 0, 6, 4, 6'b011000, 9'h100);
    tbl[7]  = mk(0, 7, 0, 0, 7, 0, 0, 6'b100100, 9'h01A);
    tbl[8]  = mk(0, 7, 0, 0, 7, 0, 0, 6'b100101, 9'h006);
    tbl[9]  = mk(7, 0, 0, 0, 7, 0, 0, 6'b000100, 9'h000);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 6'b100100, 9'h000);
    tbl[11] = mk(8, 0, 0, 0, 8, 0, 0, 6'b100000, 9'h000);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 6'b000001, 9'h006);
    tbl[13] = mk(12, 0, 2, 0, 12, 2, 0, 6'b110100, 9'h09A);
    tbl[14] = mk(0, 7, 0, 0, 7, 0, 0, 6'b100110, 9'h01A);
    idle();
    reset = 1'b1;
    #2;
    chk("reset_outs", 32'(outs()), 32'h0);
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      step();
    end
    // ecall with redirect is rejected: still RUN
    drive(mk(0, 0, 0, 0, 0, 0, 0, 6'b000011, 9'h0));
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("ecall_rejected", 32'(outs()), 32'h0);
    // ecall accepted at cycle t
    ecall_id = 1'b1;
    step();
    ecall_id = 1'b0;
    chk("drain_t1", 32'(outs()), 32'h014);
    step();
    redirect_ex = 1'b1;
    ecall_id = 1'b1;
    #1;
    chk("drain_t2_ignore", 32'(outs()), 32'h014);
    step();
    idle();
    chk("drain_t3", 32'(outs()), 32'h014);
    step();
    chk("halt_t4", 32'(outs()), 32'h019);
    drive(mk(0, 7, 5, 0, 7, 5, 0, 6'b110101, 9'h0));
    step();
    chk("halt_fwd", 32'(outs()), 32'h099);
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("halt_sticky", 32'(outs()), 32'h019);
    do_reset();
    chk("halt_reset", 32'(outs()), 32'h0);
    // reset in the middle of DRAIN
    ecall_id = 1'b1;
    step();
    ecall_id = 1'b0;
    step();
    chk("drain2_t2", 32'(outs()), 32'h014);
    reset = 1'b1;
    #1;
    chk("drain_async_reset", 32'(outs()), 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("run_after_reset", 32'(outs()), 32'h0);
    drive(tbl[7]);
    #1;
    chk("loaduse_after_reset", 32'(outs()), 32'h01A);
    step();
    idle();
    step();
    chk("loaduse_one_cycle", 32'(outs()), 32'h0);
`ifdef HAZARD_PERF_EN
    do_reset();
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    chk("flush_cnt_rst", flush_cnt, 32'd0);
    drive(tbl[7]);
    for (int i = 0; i < 3; i++) step();
    drive(tbl[8]);
    step();
    drive(tbl[12]);
    step();
    idle();
    step();
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
